// File: rtl/intersection_controller.sv
// rtl/intersection_controller.sv - two-approach traffic intersection controller with all-red clearance, WALK and flash mode
module intersection_controller #(
  parameter int NS_MIN_GREEN    = 20,
  parameter int EW_GREEN_LENGTH = 10,
  parameter int YELLOW_LENGTH   = 4,
  parameter int ALL_RED_LENGTH  = 2,
  parameter int WALK_LENGTH     = 6,
  parameter int FLASH_HALF      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_sense_ew,
  input  logic       ped_request,
  input  logic       flash_mode,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_INIT        = 3'd0,
    S_CLEAR_TO_NS = 3'd1,
    S_NS_GREEN    = 3'd2,
    S_NS_YELLOW   = 3'd3,
    S_CLEAR_TO_EW = 3'd4,
    S_EW_GREEN    = 3'd5,
    S_EW_YELLOW   = 3'd6,
    S_FLASH       = 3'd7
  } state_t;

  // One shared counter, sized for the longest interval any state can need.
  localparam int MAX_AB  = (NS_MIN_GREEN > EW_GREEN_LENGTH) ? NS_MIN_GREEN : EW_GREEN_LENGTH;
  localparam int MAX_CD  = (YELLOW_LENGTH > ALL_RED_LENGTH) ? YELLOW_LENGTH : ALL_RED_LENGTH;
  localparam int MAX_ABE = (MAX_AB > FLASH_HALF) ? MAX_AB : FLASH_HALF;
  localparam int MAX_LEN = (MAX_ABE > MAX_CD) ? MAX_ABE : MAX_CD;
  localparam int CW      = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] C_ALL_RED_LAST = CW'(ALL_RED_LENGTH - 1);
  localparam logic [CW-1:0] C_NS_MIN_LAST  = CW'(NS_MIN_GREEN - 1);
  localparam logic [CW-1:0] C_YELLOW_LAST  = CW'(YELLOW_LENGTH - 1);
  localparam logic [CW-1:0] C_EW_LAST      = CW'(EW_GREEN_LENGTH - 1);
  localparam logic [CW-1:0] C_FLASH_LAST   = CW'(FLASH_HALF - 1);
  localparam logic [CW-1:0] C_WALK_LEN     = CW'(WALK_LENGTH);

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic            r_car_latch;
  logic            r_ped_latch;
  logic            r_walk_flag;
  logic            r_ns_red, r_ns_yellow, r_ns_green;
  logic            r_ew_red, r_ew_yellow, r_ew_green;
  logic            r_walk;

  state_t          w_next_state;
  logic [CW-1:0]   w_next_count;
  logic            w_entering;
  logic            w_enter_ew;
  logic            w_next_car_latch;
  logic            w_next_ped_latch;
  logic            w_next_walk_flag;
  logic            w_blink;
  logic            w_ns_red, w_ns_yellow, w_ns_green;
  logic            w_ew_red, w_ew_yellow, w_ew_green;
  logic            w_walk;

  // Next-state selection: timer expiries and demand, with flash_mode overriding all of them.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_INIT:        w_next_state = flash_mode ? S_FLASH : S_CLEAR_TO_NS;
      S_CLEAR_TO_NS: if (r_count == C_ALL_RED_LAST) w_next_state = S_NS_GREEN;
      S_NS_GREEN:    if ((r_count >= C_NS_MIN_LAST) && (r_car_latch || r_ped_latch))
                       w_next_state = S_NS_YELLOW;
      S_NS_YELLOW:   if (r_count == C_YELLOW_LAST) w_next_state = S_CLEAR_TO_EW;
      S_CLEAR_TO_EW: if (r_count == C_ALL_RED_LAST) w_next_state = S_EW_GREEN;
      S_EW_GREEN:    if (r_count == C_EW_LAST) w_next_state = S_EW_YELLOW;
      S_EW_YELLOW:   if (r_count == C_YELLOW_LAST) w_next_state = S_CLEAR_TO_NS;
      S_FLASH:       if (!flash_mode) w_next_state = S_CLEAR_TO_NS;
      default:       w_next_state = S_INIT;
    endcase
    // INIT always completes its single cycle first; it already routes to FLASH above.
    if (flash_mode && (r_state != S_INIT)) w_next_state = S_FLASH;
  end

  // Counter: cleared on entry, saturates in idle NS green, wraps on each flash half-period.
  always_comb begin
    w_entering   = (w_next_state != r_state);
    w_next_count = r_count + CW'(1);
    if (w_entering)
      w_next_count = '0;
    else if ((r_state == S_NS_GREEN) && (r_count >= C_NS_MIN_LAST))
      w_next_count = C_NS_MIN_LAST;
    else if ((r_state == S_FLASH) && (r_count == C_FLASH_LAST))
      w_next_count = '0;
  end

  // Request latches: a new request wins over the clear that happens on EW green entry.
  always_comb begin
    w_enter_ew       = (w_next_state == S_EW_GREEN) && (r_state != S_EW_GREEN);
    w_next_car_latch = car_sense_ew | (r_car_latch & ~w_enter_ew);
    w_next_ped_latch = ped_request  | (r_ped_latch & ~w_enter_ew);
    w_next_walk_flag = w_enter_ew ? r_ped_latch : r_walk_flag;
  end

  // Lamp decode from the upcoming state so registered lamps line up with state_o.
  always_comb begin
    w_ns_red    = 1'b0;
    w_ns_yellow = 1'b0;
    w_ns_green  = 1'b0;
    w_ew_red    = 1'b0;
    w_ew_yellow = 1'b0;
    w_ew_green  = 1'b0;
    w_walk      = 1'b0;
    w_blink     = 1'b1;
    if (r_state == S_FLASH)
      w_blink = (r_count == C_FLASH_LAST) ? ~r_ns_yellow : r_ns_yellow;
    case (w_next_state)
      S_CLEAR_TO_NS, S_CLEAR_TO_EW: begin
        w_ns_red = 1'b1;
        w_ew_red = 1'b1;
      end
      S_NS_GREEN: begin
        w_ns_green = 1'b1;
        w_ew_red   = 1'b1;
      end
      S_NS_YELLOW: begin
        w_ns_yellow = 1'b1;
        w_ew_red    = 1'b1;
      end
      S_EW_GREEN: begin
        w_ns_red   = 1'b1;
        w_ew_green = 1'b1;
        w_walk     = w_next_walk_flag && (w_next_count < C_WALK_LEN);
      end
      S_EW_YELLOW: begin
        w_ns_red    = 1'b1;
        w_ew_yellow = 1'b1;
      end
      S_FLASH: begin
        w_ns_yellow = w_blink;
        w_ew_red    = w_blink;
      end
      default: begin
        w_ns_red = 1'b0;
      end
    endcase
  end

  // State, counter, latches and lamp registers; reset forces everything dark and idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_INIT;
      r_count     <= '0;
      r_car_latch <= 1'b0;
      r_ped_latch <= 1'b0;
      r_walk_flag <= 1'b0;
      r_ns_red    <= 1'b0;
      r_ns_yellow <= 1'b0;
      r_ns_green  <= 1'b0;
      r_ew_red    <= 1'b0;
      r_ew_yellow <= 1'b0;
      r_ew_green  <= 1'b0;
      r_walk      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_count     <= w_next_count;
      r_car_latch <= w_next_car_latch;
      r_ped_latch <= w_next_ped_latch;
      r_walk_flag <= w_next_walk_flag;
      r_ns_red    <= w_ns_red;
      r_ns_yellow <= w_ns_yellow;
      r_ns_green  <= w_ns_green;
      r_ew_red    <= w_ew_red;
      r_ew_yellow <= w_ew_yellow;
      r_ew_green  <= w_ew_green;
      r_walk      <= w_walk;
    end
  end

  assign ns_red      = r_ns_red;
  assign ns_yellow   = r_ns_yellow;
  assign ns_green    = r_ns_green;
  assign ew_red      = r_ew_red;
  assign ew_yellow   = r_ew_yellow;
  assign ew_green    = r_ew_green;
  assign walk        = r_walk;
  assign ped_pending = r_ped_latch;
  assign state_o     = r_state;

endmodule
